// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants, bit-order type and counter-width helper for the SIPO deserializer
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 32;

    typedef enum logic {
        LSB_FIRST,
        MSB_FIRST
    } bit_order_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: WIDTH-bit shift register with enable and clear; exposes the next shifted value
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int         WIDTH = SIPO_DEFAULT_WIDTH,
    parameter bit_order_e ORDER = LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] nxt_o
);

    logic [WIDTH-1:0] shift_d, shift_q;

    assign nxt_o = (ORDER == MSB_FIRST) ? {shift_q[WIDTH-2:0], bit_i} : {bit_i, shift_q[WIDTH-1:1]};
    assign q_o   = shift_q;

    // clear wins over shifting so a restart drops the incoming bit
    always_comb begin
        shift_d = clr_i ? '0 : (en_i ? nxt_o : shift_q);
    end

    // shift register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shift_q <= '0;
        else      shift_q <= shift_d;
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out deserializer with holding register and valid/ready output
// Define SIPO_PARITY_EN to append a parity bit to each frame and report par_err.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH      = SIPO_DEFAULT_WIDTH,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift,
    input  logic                     serial_in,
    output logic                     in_ready,
    input  logic                     restart,
    output logic [WIDTH-1:0]         shift_q,
    output logic [cnt_w(WIDTH)-1:0]  bit_cnt,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
`ifdef SIPO_PARITY_EN
    output logic                     par_err,
`endif
    input  logic                     out_ready
);

    localparam int CW = cnt_w(WIDTH);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
    localparam bit_order_e    ORDER = (MSB_FIRST != 0) ? sipo_pkg::MSB_FIRST : sipo_pkg::LSB_FIRST;

    if (WIDTH < 2 || WIDTH > 64 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("sipo_deserializer: unsupported WIDTH or PARITY_ODD");
    end

    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] data_d, data_q, nxt, word;
    logic             valid_d, valid_q, accept, complete;

    // only the completing bit stalls, and only while the held word is unconsumed
    assign in_ready = !(cnt_q == LAST && valid_q && !out_ready);
    assign accept   = shift && in_ready;
    assign complete = accept && !restart && cnt_q == LAST;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .en_i  (accept && !restart),
        .clr_i (restart || complete),
        .bit_i (serial_in),
        .q_o   (shift_q),
        .nxt_o (nxt)
    );

`ifdef SIPO_PARITY_EN
    // the parity bit is checked, not stored: the word is already complete in the shift register
    assign word = shift_q;

    logic par_d, par_q;

    // parity result follows the same capture/hold rule as out_data
    always_comb begin
        par_d = complete ? (^shift_q ^ serial_in ^ 1'(PARITY_ODD)) : par_q;
    end

    // parity error register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_q <= 1'b0;
        else      par_q <= par_d;
    end

    assign par_err = par_q;
`else
    // the completing data bit is folded in on the same edge the word is captured
    assign word = nxt;
`endif

    // frame counter, holding register and output handshake next state
    always_comb begin
        cnt_d   = (restart || complete) ? '0 : (accept ? cnt_q + 1'b1 : cnt_q);
        data_d  = complete ? word : data_q;
        valid_d = complete || (valid_q && !out_ready);
    end

    // frame counter and holding register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bit_cnt   = cnt_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed self-checking bench for LSB-first and MSB-first 8-bit deserializers
module tb_sipo_deserializer;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         shift = 1'b0;
    logic         serial_in = 1'b0;
    logic         restart = 1'b0;
    logic         out_ready = 1'b1;
    logic         l_rdy, m_rdy, l_vld, m_vld;
    logic [W-1:0] l_sq, m_sq, l_dat, m_dat;
    logic [3:0]   l_cnt, m_cnt;
    logic [15:0]  v;
    int           n_cmp = 0;
    int           n_bad = 0;
`ifdef SIPO_PARITY_EN
    logic         l_pe, m_pe;
`endif

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .serial_in (serial_in),
        .in_ready  (l_rdy),
        .restart   (restart),
        .shift_q   (l_sq),
        .bit_cnt   (l_cnt),
        .out_data  (l_dat),
        .out_valid (l_vld),
`ifdef SIPO_PARITY_EN
        .par_err   (l_pe),
`endif
        .out_ready (out_ready)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .serial_in (serial_in),
        .in_ready  (m_rdy),
        .restart   (restart),
        .shift_q   (m_sq),
        .bit_cnt   (m_cnt),
        .out_data  (m_dat),
        .out_valid (m_vld),
`ifdef SIPO_PARITY_EN
        .par_err   (m_pe),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // word with its even-parity bit appended at bit W
    function automatic logic [15:0] fr(input logic [7:0] w);
        return {7'b0, ^w, w};
    endfunction

    // bit 0 of val goes first
    task automatic send(input logic [15:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            shift = 1'b1;
            serial_in = val[i];
            tick();
        end
        shift = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_lsb", {l_sq, l_cnt, l_dat, l_vld}, 64'd0);
        check("rst_msb", {m_sq, m_cnt, m_dat, m_vld}, 64'd0);
        #5 rst = 1'b1;
        tick();
        check("rdy_after_rst", {l_rdy, m_rdy}, 64'h3);

        send(fr(8'hA5), F);
        check("a5_lsb_data", l_dat, 64'hA5);
        check("a5_msb_data", m_dat, 64'hA5);
        check("a5_valid", {l_vld, m_vld}, 64'h3);
        check("a5_cnt", {l_cnt, m_cnt}, 64'h0);
        check("a5_shq", {l_sq, m_sq}, 64'h0);
        tick();
        check("a5_valid_1cyc", {l_vld, m_vld}, 64'h0);

        v = fr(8'h3C);
        send(v, 4);
        check("3c_shq_mid", {l_sq, m_sq}, 64'hC003);
        check("3c_cnt_mid", {l_cnt, m_cnt}, 64'h44);
        tick();
        tick();
        check("3c_shq_idle", {l_sq, m_sq}, 64'hC003);
        check("3c_cnt_idle", {l_cnt, m_cnt}, 64'h44);
        send(v >> 4, F - 4);
        check("3c_data", {l_dat, m_dat}, 64'h3C3C);
        check("3c_valid", {l_vld, m_vld}, 64'h3);
        tick();

        out_ready = 1'b0;
        send(fr(8'h11), F);
        check("11_data", {l_dat, m_dat}, 64'h1188);
        check("11_valid", {l_vld, m_vld}, 64'h3);
        v = fr(8'h22);
        send(v, F - 1);
        check("bp_cnt", l_cnt, 64'(F - 1));
        check("bp_in_ready", {l_rdy, m_rdy}, 64'h0);
        shift = 1'b1;
        serial_in = v[F-1];
        tick();
        check("bp_cnt_hold", {l_cnt, m_cnt}, {56'd0, 4'(F - 1), 4'(F - 1)});
        check("bp_data_hold", {l_dat, m_dat}, 64'h1188);
        check("bp_valid_hold", {l_vld, m_vld}, 64'h3);
        out_ready = 1'b1;
        tick();
        shift = 1'b0;
        check("22_data", {l_dat, m_dat}, 64'h2244);
        check("22_valid_kept", {l_vld, m_vld}, 64'h3);
        check("22_cnt", {l_cnt, m_cnt}, 64'h0);
        tick();
        check("22_consumed", {l_vld, m_vld}, 64'h0);

        send(16'h001F, 5);
        check("rs_shq_pre", {l_sq, m_sq}, 64'hF81F);
        shift = 1'b1;
        restart = 1'b1;
        serial_in = 1'b1;
        tick();
        shift = 1'b0;
        restart = 1'b0;
        check("rs_cnt", {l_cnt, m_cnt}, 64'h0);
        check("rs_shq", {l_sq, m_sq}, 64'h0);
        check("rs_out_kept", {l_dat, m_dat, l_vld}, {47'd0, 16'h2244, 1'b0});
        send(fr(8'hFF), F);
        check("ff_data", {l_dat, m_dat}, 64'hFFFF);
        check("ff_valid", {l_vld, m_vld}, 64'h3);
        tick();

        send(16'h0007, 3);
        check("ar_shq_pre", {l_sq, m_sq}, 64'hE007);
        #3 rst = 1'b0;
        #1;
        check("ar_lsb", {l_sq, l_cnt, l_dat, l_vld}, 64'd0);
        check("ar_msb", {m_sq, m_cnt, m_dat, m_vld}, 64'd0);
        #2 rst = 1'b1;
        tick();
        tick();
        check("ar_no_valid", {l_vld, m_vld, l_cnt, m_cnt}, 64'h0);
        send(fr(8'h96), F);
        check("96_data", {l_dat, m_dat}, 64'h9669);
        tick();

`ifdef SIPO_PARITY_EN
        send(16'h0107, F);
        check("par_ok", {l_pe, m_pe}, 64'h0);
        tick();
        send(16'h0007, F);
        check("par_bad", {l_pe, m_pe}, 64'h3);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
